// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a shared multicycle MIPS datapath (PC, IR, register file,
// ALU, unified single-port memory). It sequences lw, sw, beq and R-type
// instructions and drives every datapath enable and mux select each cycle.
// Memory accesses stall on a single-port ready handshake.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   instr[31:0]    in   IR contents; only the opcode [31:26] is decoded
//   zero           in   ALU zero flag (the datapath does the beq gating)
//   mem_ready      in   memory completes the current access this cycle
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   iord           out  memory address select: 0=PC, 1=ALUOut
//   ir_write       out  load IR
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load qualified by zero (beq)
//   pc_src         out  PC source: 0=ALU result, 1=ALUOut
//   reg_write      out  register file write enable
//   reg_dst        out  write register select: 0=rt, 1=rd
//   mem_to_reg     out  write data select: 0=ALUOut, 1=MDR
//   alu_src_a      out  ALU A select: 0=PC, 1=regA
//   alu_src_b[1:0] out  ALU B select: 00=regB 01=4 10=imm 11=imm<<2
//   alu_op[1:0]    out  ALU op: 00=add 01=sub 10=funct-decoded
//   instr_done     out  pulse in the final cycle of each instruction
//   illegal_op     out  pulse in DECODE for an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        pc_src,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        instr_done,
   output logic        illegal_op
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [5:0] opcode;

   // Only the opcode is decoded; zero is consumed by the datapath's PC enable.
   logic unused_inputs;
   assign unused_inputs = ^{instr[25:0], zero};

   assign opcode = instr[31:26];

   // NOTE: state is the only flop; non-blocking assignment keeps the register
   // update race-free, and the asynchronous reset drops it to IDLE at once so
   // every state-decoded output falls to 0 without waiting for an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output and state_d gets a default before the case so no path
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REGB;
      alu_op        = ALU_ADD;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         // PC+4 is computed every fetch cycle, but IR and PC load only in the
         // cycle the memory returns the instruction.
         S_FETCH: begin
            mem_read  = 1'b1;
            iord      = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = 1'b0;
               state_d  = S_DECODE;
            end
         end

         // Speculatively compute the branch target into ALUOut.
         S_DECODE: begin
            alu_src_a = 1'b0;
            alu_src_b = SRCB_IMMSH;
            alu_op    = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end

         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            // IR is frozen after FETCH, so only lw/sw can arrive here; the
            // fallback just keeps the machine from wedging.
            if (opcode == OP_LW) begin
               state_d = S_MEMRD;
            end else if (opcode == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end
         end

         S_MEMWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         // The store retires in the same cycle the memory accepts it.
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end

         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_REGB;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end

         S_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            mem_to_reg = 1'b0;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         // The datapath forms pc_en = pc_write | (pc_write_cond & zero).
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_REGB;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end

         // Unused encodings: outputs stay at their 0 defaults, recover to IDLE.
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each cycle the bench drives inputs
// just after the falling edge, checks the full control vector (outputs are
// combinational from the state and mem_ready), then steps to the next falling
// edge. Expected vectors are written out by hand per state.
//
// Control vector bit order (17 bits, MSB first):
//   mem_read mem_write iord ir_write pc_write pc_write_cond pc_src reg_write
//   reg_dst mem_to_reg alu_src_a alu_src_b[1:0] alu_op[1:0] instr_done
//   illegal_op
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_read;
   logic        mem_write;
   logic        iord;
   logic        ir_write;
   logic        pc_write;
   logic        pc_write_cond;
   logic        pc_src;
   logic        reg_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        instr_done;
   logic        illegal_op;

   int assertions_evaluated = 0;
   int failures             = 0;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr         (instr),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .iord          (iord),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .instr_done    (instr_done),
      .illegal_op    (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [16:0] ctl;
   assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                 pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                 alu_op, instr_done, illegal_op};

   //                              mr    mw    io    irw   pcw   pwc   pcs   rw    rd    m2r   asa   asb    aop    done  ill
   localparam logic [16:0] E_IDLE   = '0;
   localparam logic [16:0] E_FWAIT  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
   localparam logic [16:0] E_FGO    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
   localparam logic [16:0] E_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
   localparam logic [16:0] E_DECILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1};
   localparam logic [16:0] E_MEMADR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
   localparam logic [16:0] E_MEMRD  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [16:0] E_MEMWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [16:0] E_WWAIT  = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [16:0] E_WGO    = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [16:0] E_EXEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
   localparam logic [16:0] E_ALUWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [16:0] E_BRANCH = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};

   localparam logic [31:0] I_LW  = 32'h8C22_0004;
   localparam logic [31:0] I_SW  = 32'hAC22_0008;
   localparam logic [31:0] I_R   = 32'h0022_1820;
   localparam logic [31:0] I_BEQ = 32'h1022_0003;
   localparam logic [31:0] I_ILL = 32'hFC00_0000;

   task automatic check(input string tag, input logic [16:0] observed,
                        input logic [16:0] expected);
      assertions_evaluated++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One controller cycle: drive mem_ready, check the settled outputs, then
   // move past the rising edge to the next falling edge.
   task automatic cyc(input string tag, input logic rdy, input logic [16:0] exp_v);
      mem_ready = rdy;
      #1;
      check(tag, ctl, exp_v);
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      instr     = I_LW;
      zero      = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc("reset_held", 1'b1, E_IDLE);

      // 1. lw, memory always ready: 5 cycles FETCH to FETCH.
      reset = 1'b0;
      cyc("lw_idle",   1'b1, E_IDLE);
      cyc("lw_fetch",  1'b1, E_FGO);
      cyc("lw_decode", 1'b1, E_DEC);
      cyc("lw_memadr", 1'b1, E_MEMADR);
      cyc("lw_memrd",  1'b1, E_MEMRD);
      cyc("lw_memwb",  1'b1, E_MEMWB);

      // 2. sw with three wait cycles in MEMWR: 7 cycles. Fetch also stalls
      //    once first, and mem_ready is driven low in DECODE to show it is
      //    ignored there.
      instr = I_SW;
      cyc("sw_fetch_wait", 1'b0, E_FWAIT);
      cyc("sw_fetch",      1'b1, E_FGO);
      cyc("sw_decode",     1'b0, E_DEC);
      cyc("sw_memadr",     1'b1, E_MEMADR);
      cyc("sw_memwr_w0",   1'b0, E_WWAIT);
      cyc("sw_memwr_w1",   1'b0, E_WWAIT);
      cyc("sw_memwr_w2",   1'b0, E_WWAIT);
      cyc("sw_memwr_go",   1'b1, E_WGO);

      // 3. R-type: 4 cycles.
      instr = I_R;
      cyc("r_fetch",  1'b1, E_FGO);
      cyc("r_decode", 1'b1, E_DEC);
      cyc("r_exec",   1'b0, E_EXEC);
      cyc("r_aluwb",  1'b1, E_ALUWB);

      // 4. beq taken then not taken: 3 cycles each, identical outputs.
      instr = I_BEQ;
      zero  = 1'b1;
      cyc("beq1_fetch",  1'b1, E_FGO);
      cyc("beq1_decode", 1'b1, E_DEC);
      cyc("beq1_branch", 1'b1, E_BRANCH);
      zero  = 1'b0;
      cyc("beq0_fetch",  1'b1, E_FGO);
      cyc("beq0_decode", 1'b1, E_DEC);
      cyc("beq0_branch", 1'b1, E_BRANCH);

      // lw with a read stall: MEMRD held one extra cycle.
      instr = I_LW;
      cyc("lws_fetch",  1'b1, E_FGO);
      cyc("lws_decode", 1'b1, E_DEC);
      cyc("lws_memadr", 1'b1, E_MEMADR);
      cyc("lws_memrd0", 1'b0, E_MEMRD);
      cyc("lws_memrd1", 1'b1, E_MEMRD);
      cyc("lws_memwb",  1'b1, E_MEMWB);

      // 5. Illegal opcode 0x3F: 2 cycles, back to FETCH.
      instr = I_ILL;
      cyc("ill_fetch",  1'b1, E_FGO);
      cyc("ill_decode", 1'b1, E_DECILL);

      // 6. Reset while MEMWR is stalled: mem_write drops without an edge.
      instr = I_SW;
      cyc("rst_fetch",  1'b1, E_FGO);
      cyc("rst_decode", 1'b1, E_DEC);
      cyc("rst_memadr", 1'b1, E_MEMADR);
      mem_ready = 1'b0;
      #1;
      check("rst_memwr_before", ctl, E_WWAIT);
      reset = 1'b1;
      #1;
      check("rst_memwr_async", ctl, E_IDLE);
      @(negedge clk);
      cyc("rst_hold",   1'b1, E_IDLE);
      reset = 1'b0;
      cyc("rst_idle",   1'b1, E_IDLE);
      cyc("rst_fetch2", 1'b1, E_FGO);
      cyc("rst_decode2", 1'b1, E_DEC);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertions_evaluated, failures);
      $finish;
   end

endmodule
